// File: rtl/fwd_scoreboard.sv
// Forwarding / load-use hazard scoreboard for the 5-stage pipeline.
// Tracks in-flight register writes in a DEPTH-entry shift register (entry 0 = EX),
// raises a combinational load-use stall for the instruction in ID and registers
// per-operand forwarding selects that the instruction consumes once it reaches EX.
// Optional feature macro: STALL_CNT_EN adds a saturating 32-bit stall counter port.

// Per-operand lookup: youngest matching producer decides select and readiness.
module fwd_operand #(
    parameter int REG_AW     = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 2,
    parameter int SEL_W      = 2
) (
    input  logic [REG_AW-1:0]             rs,
    input  logic [DEPTH-1:0]              vld,
    input  logic [DEPTH-1:0][REG_AW-1:0]  rd,
    input  logic [DEPTH-1:0]              ld,
    output logic [SEL_W-1:0]              sel,
    output logic                          need_stall
);
    // Scan oldest to youngest so the youngest match overwrites older duplicates.
    always_comb begin
        sel        = '0;
        need_stall = 1'b0;
        for (int k = DEPTH-1; k >= 0; k--) begin
            if (vld[k] && (rd[k] == rs) && (rs != '0)) begin
                sel        = SEL_W'(k+1);
                need_stall = ld[k] && ((k+1) < LOAD_READY);
            end
        end
    end
endmodule

module fwd_scoreboard #(
    parameter int REG_AW     = 5,
    parameter int NUM_SRC    = 2,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 2,
    localparam int SEL_W     = $clog2(DEPTH+1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0]         id_rd,
    input  logic                      id_regwrite,
    input  logic                      id_is_load,
    input  logic                      hold,
    input  logic                      flush,
    output logic                      stall,
    output logic [NUM_SRC*SEL_W-1:0]  ex_fwd_sel
`ifdef STALL_CNT_EN
    ,
    output logic [31:0]               stall_cnt
`endif
);
    logic [DEPTH-1:0]                 vld_pipe;
    logic [DEPTH-1:0][REG_AW-1:0]     rd_pipe;
    logic [DEPTH-1:0]                 ld_pipe;
    logic [NUM_SRC-1:0][SEL_W-1:0]    sel;
    logic [NUM_SRC-1:0][SEL_W-1:0]    ex_sel_q;
    logic [NUM_SRC-1:0]               need;
    logic                             issue;

    genvar g;
    generate
        for (g = 0; g < NUM_SRC; g++) begin : g_op
            fwd_operand #(
                .REG_AW     (REG_AW),
                .DEPTH      (DEPTH),
                .LOAD_READY (LOAD_READY),
                .SEL_W      (SEL_W)
            ) u_op (
                .rs         (id_rs[g*REG_AW +: REG_AW]),
                .vld        (vld_pipe),
                .rd         (rd_pipe),
                .ld         (ld_pipe),
                .sel        (sel[g]),
                .need_stall (need[g])
            );
        end
    endgenerate

    // Flush dominates stall: a squashed instruction cannot wait on anything.
    assign stall      = id_valid && !flush && (|need);
    assign issue      = id_valid && !flush && !stall;
    assign ex_fwd_sel = ex_sel_q;

    // Producer shift register and EX select register; both freeze under hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            rd_pipe  <= '0;
            ld_pipe  <= '0;
            ex_sel_q <= '0;
        end else if (!hold) begin
            for (int k = DEPTH-1; k >= 1; k--) begin
                vld_pipe[k] <= vld_pipe[k-1];
                rd_pipe[k]  <= rd_pipe[k-1];
                ld_pipe[k]  <= ld_pipe[k-1];
            end
            vld_pipe[0] <= issue && id_regwrite && (id_rd != '0);
            rd_pipe[0]  <= id_rd;
            ld_pipe[0]  <= id_is_load;
            ex_sel_q    <= issue ? sel : '0;
        end
    end

`ifdef STALL_CNT_EN
    // Saturating count of cycles spent in a non-held load-use stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (stall && !hold && (stall_cnt != 32'hFFFF_FFFF))
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard with an age-based reference model checked every negedge.
module tb_fwd_scoreboard;
    localparam int REG_AW = 5, NUM_SRC = 2, DEPTH = 3, LOAD_READY = 2, SEL_W = 2;

    logic       clk = 1'b0, rst_n = 1'b1;
    logic       id_valid = 1'b0, id_regwrite = 1'b0, id_is_load = 1'b0, hold = 1'b0, flush = 1'b0;
    logic [9:0] id_rs = '0;
    logic [4:0] id_rd = '0;
    logic       stall;
    logic [3:0] ex_fwd_sel;
`ifdef STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int n_chk = 0, n_fail = 0;

    fwd_scoreboard #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .LOAD_READY(LOAD_READY)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_is_load(id_is_load), .hold(hold), .flush(flush),
        .stall(stall), .ex_fwd_sel(ex_fwd_sel)
`ifdef STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: list of recent issue slots, newest first; slot a has age a+1 cycles in the pipe.
    typedef struct { bit v; bit [4:0] rd; bit ld; } slot_t;
    slot_t       hist[$];
    logic [3:0]  m_sel = '0;
    logic [31:0] m_cnt = '0;

    always @(negedge clk) begin
        logic [3:0] nsel;
        logic [4:0] rs;
        bit         need, exp_stall, issue;
        slot_t      s;
        if (!rst_n) begin
            hist.delete();
            m_sel = '0;
            m_cnt = '0;
            chk("rst_stall", {31'd0, stall}, 32'd0);
            chk("rst_sel", {28'd0, ex_fwd_sel}, 32'd0);
        end else begin
            nsel = '0;
            need = 0;
            for (int i = 0; i < NUM_SRC; i++) begin
                rs = id_rs[i*REG_AW +: REG_AW];
                if (rs != 0) begin
                    for (int a = 0; a < hist.size(); a++) begin
                        if (hist[a].v && hist[a].rd == rs) begin
                            nsel[i*SEL_W +: SEL_W] = 2'(a + 1);
                            // load data exists only once the producer is LOAD_READY cycles old
                            if (hist[a].ld && (a + 1) < LOAD_READY) need = 1;
                            break;
                        end
                    end
                end
            end
            exp_stall = id_valid && !flush && need;
            chk("model_stall", {31'd0, stall}, {31'd0, exp_stall});
            chk("model_sel", {28'd0, ex_fwd_sel}, {28'd0, m_sel});
`ifdef STALL_CNT_EN
            chk("model_cnt", stall_cnt, m_cnt);
`endif
            if (!hold) begin
                issue = id_valid && !flush && !exp_stall;
                s.v  = issue && id_regwrite && (id_rd != 0);
                s.rd = id_rd;
                s.ld = id_is_load;
                hist.push_front(s);
                if (hist.size() > DEPTH) void'(hist.pop_back());
                m_sel = issue ? nsel : 4'd0;
                if (exp_stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input bit [4:0] r0, input bit [4:0] r1, input bit [4:0] rd,
                         input bit rw, input bit ld);
        id_valid = v; id_rs = {r1, r0}; id_rd = rd; id_regwrite = rw; id_is_load = ld;
    endtask

    task automatic drain();
        drive(0, 0, 0, 0, 0, 0);
        repeat (3) step();
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) step();
        chk("reset_stall", {31'd0, stall}, 32'd0);
        chk("reset_sel", {28'd0, ex_fwd_sel}, 32'd0);
        rst_n = 1'b1;

        // add r3 ; sub rs=r3 -> EX/MEM forward, no stall
        drive(1, 1, 2, 3, 1, 0); step();
        drive(1, 3, 0, 6, 1, 0); #1 chk("alu_stall", {31'd0, stall}, 32'd0);
        step(); chk("alu_sel", {28'd0, ex_fwd_sel}, 32'h1);
        drain();

        // lw r5 ; add rs1=r5 -> one stall cycle, bubble, then MEM/WB forward
        drive(1, 0, 0, 5, 1, 1); step();
        drive(1, 0, 5, 7, 1, 0); #1 chk("lu_stall", {31'd0, stall}, 32'd1);
        step(); chk("lu_bubble", {28'd0, ex_fwd_sel}, 32'h0);
        #1 chk("lu_release", {31'd0, stall}, 32'd0);
        step(); chk("lu_sel", {28'd0, ex_fwd_sel}, 32'h8);
        drain();

        // add r4 ; add r4 ; or r4,r4 -> youngest wins
        drive(1, 0, 0, 4, 1, 0); step();
        drive(1, 0, 0, 4, 1, 0); step();
        drive(1, 4, 4, 8, 1, 0); #1 chk("dup_stall", {31'd0, stall}, 32'd0);
        step(); chk("dup_sel", {28'd0, ex_fwd_sel}, 32'h5);
        drain();

        // load writing r0, consumer of r0 -> never tracked
        drive(1, 0, 0, 0, 1, 1); step();
        drive(1, 0, 0, 11, 1, 0); #1 chk("r0_stall", {31'd0, stall}, 32'd0);
        step(); chk("r0_sel", {28'd0, ex_fwd_sel}, 32'h0);
        drain();

        // flush during load-use hazard -> no stall, flushed writer not tracked
        drive(1, 0, 0, 9, 1, 1); step();
        drive(1, 9, 0, 10, 1, 0); flush = 1'b1;
        #1 chk("flush_stall", {31'd0, stall}, 32'd0);
        step(); flush = 1'b0; chk("flush_sel", {28'd0, ex_fwd_sel}, 32'h0);
        drive(1, 10, 9, 11, 1, 0); #1 chk("postflush_stall", {31'd0, stall}, 32'd0);
        step(); chk("postflush_sel", {28'd0, ex_fwd_sel}, 32'h8);
        drain();

        // hold three cycles during a load-use hazard
        drive(1, 0, 0, 1, 1, 0); step();
        drive(1, 1, 0, 12, 1, 1); step();
        chk("lw_sel", {28'd0, ex_fwd_sel}, 32'h1);
        drive(1, 12, 0, 13, 1, 0); #1 chk("hold_pre_stall", {31'd0, stall}, 32'd1);
        hold = 1'b1;
        repeat (3) begin
            step();
            chk("hold_stall", {31'd0, stall}, 32'd1);
            chk("hold_sel", {28'd0, ex_fwd_sel}, 32'h1);
        end
        hold = 1'b0;
        step(); chk("hold_bubble", {28'd0, ex_fwd_sel}, 32'h0);
        chk("hold_release", {31'd0, stall}, 32'd0);
        step(); chk("hold_fwd_sel", {28'd0, ex_fwd_sel}, 32'h2);
        drain();
`ifdef STALL_CNT_EN
        chk("stall_cnt_two", stall_cnt, 32'd2);
`endif

        // reset mid-run clears a pending hazard
        drive(1, 0, 0, 14, 1, 1); step();
        drive(1, 14, 0, 15, 1, 0); #1 chk("pre_rst_stall", {31'd0, stall}, 32'd1);
        rst_n = 1'b0;
        #1 chk("mid_rst_stall", {31'd0, stall}, 32'd0);
`ifdef STALL_CNT_EN
        chk("mid_rst_cnt", stall_cnt, 32'd0);
`endif
        step(); rst_n = 1'b1;
        #1 chk("post_rst_stall", {31'd0, stall}, 32'd0);
        step(); chk("post_rst_sel", {28'd0, ex_fwd_sel}, 32'h0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
